// File: rtl/sync_search_ctrl.sv
// rtl/sync_search_ctrl.sv - acquisition/tracking sequencer for the sync-measurement block
//
// Purpose:
//    Steps through LLR-former phase rotations and depuncturer states while
//    searching for sync. Lock needs a run of good measurement periods, and
//    loss needs a run of bad ones. The period after every hypothesis change
//    is blanked because its measurement window straddled the change.
//
// Ports:
//    clk, reset_n        clock, asynchronous active-low reset
//    i_enable            search/track enable (level); low forces IDLE
//    i_num_phases        phase rotation count (0 acts as 1)
//    i_num_deperf        depuncturer state count (0 acts as 1)
//    i_confirm_cnt       good periods needed to lock (0 acts as 1)
//    i_loss_cnt          bad periods needed to drop lock (0 acts as 1)
//    i_period_stb        end-of-period strobe
//    i_period_good       period verdict, valid with i_period_stb
//    o_next_phase        pulse: rotate LLR-former phase
//    o_deperf_next_st    pulse: advance depuncturer state
//    o_llr_reset         pulse: return LLR former/depuncturer to state 0
//    o_is_sync           lock flag
//    o_sync_lost         pulse: lock dropped
//    o_search_wrap       pulse: full phase x depuncturer sweep completed
//    o_phase_idx         current phase hypothesis
//    o_deperf_idx        current depuncturer hypothesis
//    o_state             IDLE=0 SEARCH=1 BLANK=2 VERIFY=3 LOCKED=4
module sync_search_ctrl #(
   parameter int PH_W  = 2,
   parameter int DP_W  = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_enable,
   input  logic [PH_W-1:0]  i_num_phases,
   input  logic [DP_W-1:0]  i_num_deperf,
   input  logic [CNT_W-1:0] i_confirm_cnt,
   input  logic [CNT_W-1:0] i_loss_cnt,
   input  logic             i_period_stb,
   input  logic             i_period_good,
   output logic             o_next_phase,
   output logic             o_deperf_next_st,
   output logic             o_llr_reset,
   output logic             o_is_sync,
   output logic             o_sync_lost,
   output logic             o_search_wrap,
   output logic [PH_W-1:0]  o_phase_idx,
   output logic [DP_W-1:0]  o_deperf_idx,
   output logic [2:0]       o_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SEARCH = 3'd1,
      BLANK  = 3'd2,
      VERIFY = 3'd3,
      LOCKED = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] good_cnt, good_nxt, good_inc;
   logic [CNT_W-1:0] miss_cnt, miss_nxt, miss_inc;
   logic [PH_W-1:0]  phase_nxt, st_phase;
   logic [DP_W-1:0]  deperf_nxt, st_deperf;
   logic             st_np, st_dp, st_wrap;
   logic             do_step, loss_evt;
   logic             np_nxt, dp_nxt, llr_nxt, lost_nxt, wrap_nxt, sync_nxt;

   // Zero-valued configuration is treated as one.
   logic [PH_W-1:0]  n_ph;
   logic [DP_W-1:0]  n_dp;
   logic [CNT_W-1:0] conf_eff, loss_eff;

   assign n_ph     = (i_num_phases  == '0) ? PH_W'(1)  : i_num_phases;
   assign n_dp     = (i_num_deperf  == '0) ? DP_W'(1)  : i_num_deperf;
   assign conf_eff = (i_confirm_cnt == '0) ? CNT_W'(1) : i_confirm_cnt;
   assign loss_eff = (i_loss_cnt    == '0) ? CNT_W'(1) : i_loss_cnt;

   // Saturating increments: counters stick at all-ones.
   assign good_inc = (good_cnt == '1) ? good_cnt : good_cnt + CNT_W'(1);
   assign miss_inc = (miss_cnt == '1) ? miss_cnt : miss_cnt + CNT_W'(1);

   // STEP candidate, always computed from the current hypothesis. An index
   // left out of range by a config change falls into the carry/reset path.
   always_comb begin
      st_phase  = o_phase_idx;
      st_deperf = o_deperf_idx;
      st_np     = 1'b0;
      st_dp     = 1'b0;
      st_wrap   = 1'b0;
      if (o_phase_idx < n_ph - PH_W'(1)) begin
         st_phase = o_phase_idx + PH_W'(1);
         st_np    = 1'b1;
         if (o_deperf_idx >= n_dp) begin
            st_deperf = '0;
         end
      end else begin
         st_phase = '0;
         st_dp    = 1'b1;
         if (o_deperf_idx < n_dp - DP_W'(1)) begin
            st_deperf = o_deperf_idx + DP_W'(1);
         end else begin
            st_deperf = '0;
            st_wrap   = 1'b1;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      miss_nxt  = miss_cnt;
      do_step   = 1'b0;
      loss_evt  = 1'b0;
      if (!i_enable) begin
         state_nxt = IDLE;
         good_nxt  = '0;
         miss_nxt  = '0;
      end else begin
         case (state)
            IDLE: state_nxt = SEARCH;
            SEARCH: begin
               if (i_period_stb) begin
                  if (i_period_good) begin
                     good_nxt  = CNT_W'(1);
                     state_nxt = (conf_eff <= CNT_W'(1)) ? LOCKED : VERIFY;
                  end else begin
                     do_step = 1'b1;
                  end
               end
            end
            // The strobe following a change is discarded.
            BLANK: begin
               if (i_period_stb) begin
                  state_nxt = SEARCH;
               end
            end
            VERIFY: begin
               if (i_period_stb) begin
                  if (i_period_good) begin
                     good_nxt = good_inc;
                     if (good_inc >= conf_eff) begin
                        state_nxt = LOCKED;
                     end
                  end else begin
                     good_nxt = '0;
                     do_step  = 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (i_period_stb) begin
                  if (i_period_good) begin
                     miss_nxt = '0;
                  end else if (miss_inc >= loss_eff) begin
                     miss_nxt = '0;
                     loss_evt = 1'b1;
                     do_step  = 1'b1;
                  end else begin
                     miss_nxt = miss_inc;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
         if (do_step) begin
            state_nxt = BLANK;
         end
      end
      phase_nxt  = !i_enable ? '0 : (do_step ? st_phase  : o_phase_idx);
      deperf_nxt = !i_enable ? '0 : (do_step ? st_deperf : o_deperf_idx);
   end

   // Output logic (values registered on the next edge).
   always_comb begin
      np_nxt   = do_step & st_np;
      dp_nxt   = do_step & st_dp;
      wrap_nxt = do_step & st_wrap;
      lost_nxt = loss_evt;
      llr_nxt  = i_enable && (state == IDLE);
      sync_nxt = (state_nxt == LOCKED);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= IDLE;
         good_cnt         <= '0;
         miss_cnt         <= '0;
         o_phase_idx      <= '0;
         o_deperf_idx     <= '0;
         o_next_phase     <= 1'b0;
         o_deperf_next_st <= 1'b0;
         o_llr_reset      <= 1'b0;
         o_is_sync        <= 1'b0;
         o_sync_lost      <= 1'b0;
         o_search_wrap    <= 1'b0;
      end else begin
         state            <= state_nxt;
         good_cnt         <= good_nxt;
         miss_cnt         <= miss_nxt;
         o_phase_idx      <= phase_nxt;
         o_deperf_idx     <= deperf_nxt;
         o_next_phase     <= np_nxt;
         o_deperf_next_st <= dp_nxt;
         o_llr_reset      <= llr_nxt;
         o_is_sync        <= sync_nxt;
         o_sync_lost      <= lost_nxt;
         o_search_wrap    <= wrap_nxt;
      end
   end

   assign o_state = state;

endmodule
